toggle_handshake_rx: RTL and testbench
======================================

Name: toggle_handshake_rx

Overview:
- Receiving end of a two-phase (toggle) request/acknowledge link.
- The sender drives a T-flip-flop-style request line (req_t) that flips once per transfer, and holds data_in stable until ack_t flips back.
- This block synchronises req_t, detects each toggle, captures data_in, and presents the word downstream on a valid/ready interface.
- When the word is consumed, it toggles ack_t back to the sender. Sits at the boundary between the toggle-signalling producer and clk-domain consumers.

Parameters:
DATA_W, 8, width of data_in / out_data
SYNC_STAGES, 2, flops in the req_t synchroniser chain (legal 2..4)
CNT_W, 8, width of the completed-transfer counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
req_t  input  1  toggle request from sender; each level change = one new word
data_in  input  DATA_W  sender data, stable from req_t toggle until ack_t toggle
ack_t  output  1  toggle acknowledge to sender; flips once per consumed word
out_data  output  DATA_W  captured word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  downstream accepts out_data when high with out_valid
evt_count  output  CNT_W  number of completed transfers, wraps
proto_err  output  1  sticky: sender toggled again before ack
err_clr  input  1  synchronous clear of proto_err

Behaviour:
- Reset (rst_n low, asynchronous): the following all go to 0 and state goes to IDLE:
  - sync chain, req_last
  - ack_t, out_valid, out_data
  - evt_count, proto_err
- Reset mid-transfer drops the pending word. The sender is reset on the same rst_n.
- Synchroniser: req_t passes through SYNC_STAGES flops; the last stage is req_sync. toggle_seen = (req_sync != req_last), combinational.
- FSM, two states:
  - IDLE:
    - out_valid=0.
    - On toggle_seen: out_data<=data_in, req_last<=req_sync, out_valid<=1, go to PRESENT.
  - PRESENT:
    - out_valid=1; out_data and ack_t held constant.
    - On the edge with out_ready=1: out_valid<=0, ack_t<=~ack_t, evt_count<=evt_count+1 (mod 2^CNT_W), req_last<=req_sync, go to IDLE.
- Latency:
  - out_valid rises on the (SYNC_STAGES+1)th rising edge after req_t changes, counting the first sampling edge as 1. With defaults, that is 3 edges.
  - ack_t flips on the same edge that completes the out_valid/out_ready transfer.
  - Minimum round trip is therefore SYNC_STAGES+2 edges from req_t change to ack_t change, with out_ready held high.
- out_ready may be high before out_valid; no combinational path from out_ready to out_valid or ack_t.
- Protocol violation:
  - In PRESENT, req_sync != req_last means the sender toggled again before ack: set proto_err.
  - The extra toggle is discarded, because req_last is reloaded from req_sync on exit from PRESENT. No second word is presented.
  - The violating toggle produces no ack_t flip.
- proto_err clearing:
  - proto_err clears only on err_clr=1.
  - If a set and err_clr occur in the same cycle, the set wins.
- Back-to-back transfers: after returning to IDLE, a new toggle already present on req_sync is captured on the next edge. There is no idle bubble beyond that one cycle.
- Counter wrap: with CNT_W=8, evt_count goes 255 -> 0 silently; no flag.
- All outputs are registered.

Test Plan:
- Reset with req_t=0 -> ack_t=0, out_valid=0, out_data=0x00, evt_count=0, proto_err=0.
- req_t 0->1 with data_in=0xA5, out_ready=1 -> out_valid high on edge 3 after change, out_data=0xA5. On edge 4: ack_t=1, out_valid=0, evt_count=1.
- Hold out_ready=0 for 10 cycles after capture of 0x3C -> out_valid and out_data=0x3C stable, ack_t unchanged. Raise out_ready -> ack_t flips on that edge, evt_count increments once.
- Sender toggles req_t 1->0 with data 0x11 while a word is still in PRESENT (out_ready=0) -> proto_err=1, no second word after consumption, single ack_t flip. Then err_clr=1 for one cycle -> proto_err=0.
- 256 well-formed transfers with data = index -> each out_data matches its index, ack_t toggles 256 times, evt_count returns to 0.
- Assert rst_n low while out_valid=1 -> all outputs 0 immediately, without waiting for clk. After release, a fresh toggle is captured normally.

Source files
------------

// File: rtl/toggle_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_rx
// Purpose  : Receive side of a two-phase req/ack link; presents each word on
//            a valid/ready port and returns a toggled ack once it is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_handshake_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_t,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_t,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              proto_err,
  input  logic              err_clr
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                r_req_last;
  logic                r_ack;
  logic                r_valid;
  logic                r_err;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_count;
  logic                w_req_sync;
  logic                w_toggle_seen;
  logic                w_capture;
  logic                w_consume;
  logic                w_violation;

  assign w_req_sync    = r_sync[SYNC_STAGES-1];
  assign w_toggle_seen = w_req_sync ^ r_req_last;

  // req_t is asynchronous to clk: shift it through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_t};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    w_violation = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_toggle_seen) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // Any toggle while a word is still held means the sender ran ahead.
        w_violation = w_toggle_seen;
        if (out_ready) begin
          w_consume   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reloading req_last on exit swallows any extra toggle seen during PRESENT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_last <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ack      <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_capture || w_consume) begin
        r_req_last <= w_req_sync;
      end
      if (w_capture) begin
        r_data  <= data_in;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      if (w_consume) begin
        r_ack   <= ~r_ack;
        r_count <= r_count + c_cnt_one;
      end
    end
  end

  // Set has priority over clear so a persisting violation is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_violation) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign ack_t     = r_ack;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign evt_count = r_count;
  assign proto_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_toggle_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_handshake_rx
// Purpose  : Self-checking bench for toggle_handshake_rx with a word-queue
//            reference model and randomised ready/idle timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_handshake_rx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              req_t     = 1'b0;
  logic [DATA_W-1:0] data_in   = '0;
  logic              out_ready = 1'b0;
  logic              err_clr   = 1'b0;
  logic              ack_t;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CNT_W-1:0]  evt_count;
  logic              proto_err;

  int n_checks  = 0;
  int n_pass    = 0;
  int ack_edges = 0;

  // Reference model: words in flight, expected ack level, expected count.
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_ack = 1'b0;
  logic [CNT_W-1:0]  exp_cnt = '0;

  toggle_handshake_rx #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_t    (req_t),
    .data_in  (data_in),
    .ack_t    (ack_t),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .evt_count(evt_count),
    .proto_err(proto_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  always @(ack_t) ack_edges++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_t     = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    exp_q.delete();
    exp_ack   = 1'b0;
    exp_cnt   = '0;
    ack_edges = 0;
  endtask

  // Well-behaved sender: one toggle, then wait for the ack before returning.
  task automatic send_word(input logic [DATA_W-1:0] d);
    bit                done;
    bit                hs;
    logic [DATA_W-1:0] seen;
    done    = 1'b0;
    data_in = d;
    req_t   = ~req_t;
    exp_q.push_back(d);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      hs        = out_valid && out_ready;
      seen      = out_data;
      step();
      if (hs) begin
        check_eq("rand_data", seen, exp_q.pop_front());
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + 1'b1;
        check_eq("rand_ack", ack_t, exp_ack);
        check_eq("rand_cnt", evt_count, exp_cnt);
        check_eq("rand_valid_drop", out_valid, 1'b0);
        done = 1'b1;
      end else begin
        check_eq("rand_ack_hold", ack_t, exp_ack);
      end
    end
    if (!done) begin
      check_eq("rand_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
  endtask

  initial begin
    do_reset();
    check_eq("rst_ack", ack_t, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_data", out_data, 8'h00);
    check_eq("rst_cnt", evt_count, 8'h00);
    check_eq("rst_err", proto_err, 1'b0);

    // Minimum latency with ready held high.
    req_t = 1'b1; data_in = 8'hA5; out_ready = 1'b1;
    step(); check_eq("lat_e1_valid", out_valid, 1'b0);
    step(); check_eq("lat_e2_valid", out_valid, 1'b0);
    step(); check_eq("lat_e3_valid", out_valid, 1'b1);
            check_eq("lat_e3_data", out_data, 8'hA5);
            check_eq("lat_e3_ack", ack_t, 1'b0);
    step(); check_eq("lat_e4_ack", ack_t, 1'b1);
            check_eq("lat_e4_valid", out_valid, 1'b0);
            check_eq("lat_e4_cnt", evt_count, 8'd1);

    // Backpressure: word held while ready is low.
    out_ready = 1'b0; req_t = 1'b0; data_in = 8'h3C;
    repeat (3) step();
    check_eq("bp_valid", out_valid, 1'b1);
    check_eq("bp_data", out_data, 8'h3C);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_hold_valid", out_valid, 1'b1);
      check_eq("bp_hold_data", out_data, 8'h3C);
      check_eq("bp_hold_ack", ack_t, 1'b1);
    end
    out_ready = 1'b1;
    step();
    check_eq("bp_ack", ack_t, 1'b0);
    check_eq("bp_cnt", evt_count, 8'd2);
    check_eq("bp_valid_drop", out_valid, 1'b0);

    // Protocol violation: sender toggles again before the ack.
    out_ready = 1'b0; req_t = 1'b1; data_in = 8'h77;
    repeat (3) step();
    check_eq("pv_valid", out_valid, 1'b1);
    req_t = 1'b0; data_in = 8'h11;
    repeat (4) step();
    check_eq("pv_err", proto_err, 1'b1);
    check_eq("pv_data_kept", out_data, 8'h77);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("pv_set_wins", proto_err, 1'b1);
    out_ready = 1'b1;
    step();
    check_eq("pv_ack", ack_t, 1'b1);
    check_eq("pv_cnt", evt_count, 8'd3);
    check_eq("pv_valid_drop", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("pv_no_second_valid", out_valid, 1'b0);
      check_eq("pv_no_second_ack", ack_t, 1'b1);
    end
    check_eq("pv_err_sticky", proto_err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("pv_err_clr", proto_err, 1'b0);
    exp_ack = 1'b1;
    exp_cnt = 8'd3;

    // Asynchronous reset while a word is presented.
    out_ready = 1'b0; req_t = 1'b1; data_in = 8'h5A;
    repeat (3) step();
    check_eq("ar_pre_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    req_t = 1'b0;
    #1;
    check_eq("ar_ack", ack_t, 1'b0);
    check_eq("ar_valid", out_valid, 1'b0);
    check_eq("ar_data", out_data, 8'h00);
    check_eq("ar_cnt", evt_count, 8'h00);
    check_eq("ar_err", proto_err, 1'b0);
    do_reset();
    send_word(8'hC3);
    check_eq("ar_fresh_cnt", evt_count, 8'd1);

    // 256 well-formed transfers, data = index, random gaps and stalls.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_word(i[DATA_W-1:0]);
      repeat ($urandom_range(0, 2)) begin
        out_ready = $urandom_range(0, 1);
        step();
      end
    end
    check_eq("wrap_cnt", evt_count, 8'd0);
    check_eq("wrap_ack_edges", ack_edges, 256);
    check_eq("wrap_ack_level", ack_t, 1'b0);
    check_eq("wrap_err", proto_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
